// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchronized, counter-qualified input debouncer
//
// Purpose: cleans a raw bouncing switch/pushbutton level. Din is synchronized
// through s1 -> s2, and a level change on s2 is accepted only after it has been
// seen for STABLE_CYCLES+1 consecutive samples. Accepted changes update Q and
// emit a one-cycle Rise or Fall pulse.
//
// Ports:
//   Clk   - single clock, all state updates on its rising edge
//   Reset - synchronous active-low reset
//   Din   - raw asynchronous input
//   Q     - debounced level (registered)
//   Rise  - one-cycle pulse on an accepted 0->1 change of Q (registered)
//   Fall  - one-cycle pulse on an accepted 1->0 change of Q (registered)
//   Busy  - high while a candidate level change is being qualified (registered)

module input_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Din,
    output logic Q,
    output logic Rise,
    output logic Fall,
    output logic Busy
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Busy is written alongside every state change so it always equals
    // (state is a CHK state) without any decode after the flop.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            Q     <= 1'b0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            s1   <= Din;
            s2   <= s1;
            Rise <= 1'b0;
            Fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s2) begin
                        state <= CHK_HI;
                        cnt   <= CNT_ONE;
                        Busy  <= 1'b1;
                    end
                end
                CHK_HI: begin
                    if (!s2) begin
                        // glitch rejected, no pulse
                        state <= STABLE_LO;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        Q     <= 1'b1;
                        Rise  <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s2) begin
                        state <= CHK_LO;
                        cnt   <= CNT_ONE;
                        Busy  <= 1'b1;
                    end
                end
                CHK_LO: begin
                    if (s2) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        Q     <= 1'b0;
                        Fall  <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench for input_debouncer (STABLE_CYCLES=4 and 1)

module tb_input_debouncer;

    logic Clk;
    logic Reset;
    logic Din;
    logic q0, rise0, fall0, busy0;
    logic q1, rise1, fall1, busy1;

    int total = 0;
    int bad   = 0;

    input_debouncer #(.STABLE_CYCLES(4), .CNT_W(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .Din(Din),
        .Q(q0), .Rise(rise0), .Fall(fall0), .Busy(busy0)
    );

    input_debouncer #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
        .Clk(Clk), .Reset(Reset), .Din(Din),
        .Q(q1), .Rise(rise1), .Fall(fall1), .Busy(busy1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: the input seen by the qualifier is Din delayed by two
    // sampling edges; a level opposite to Q must be seen on SC+1 consecutive
    // samples before Q takes it. Expected {Q,Rise,Fall,Busy} per edge.
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    bit         d1[2];
    bit         d2[2];
    bit         mq[2];
    int         run[2];

    task automatic model_step(input int k, input int sc, input bit din,
                              input bit rst_n, output logic [3:0] e);
        bit seen;
        if (!rst_n) begin
            d1[k] = 0; d2[k] = 0; mq[k] = 0; run[k] = 0;
            e = 4'b0000;
        end else begin
            seen  = d2[k];
            d2[k] = d1[k];
            d1[k] = din;
            run[k] = (seen != mq[k]) ? run[k] + 1 : 0;
            if (run[k] == sc + 1) begin
                mq[k]  = ~mq[k];
                run[k] = 0;
                e = {mq[k], mq[k], ~mq[k], 1'b0};
            end else begin
                e = {mq[k], 1'b0, 1'b0, (run[k] != 0)};
            end
        end
    endtask

    always @(posedge Clk) begin
        logic [3:0] e0, e1;
        model_step(0, 4, Din, Reset, e0);
        model_step(1, 1, Din, Reset, e1);
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
    end

    // Monitor: pops expectations and compares against what each DUT presents.
    always @(negedge Clk) begin
        logic [3:0] e, a;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            a = {q0, rise0, fall0, busy0};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL sc4_outputs t=%0t got QRFB=%b want QRFB=%b", $time, a, e);
            end
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            a = {q1, rise1, fall1, busy1};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL sc1_outputs t=%0t got QRFB=%b want QRFB=%b", $time, a, e);
            end
        end
    end

    task automatic drive(input bit din, input bit rst_n, input int n);
        for (int i = 0; i < n; i++) begin
            Din   = din;
            Reset = rst_n;
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        Din   = 1'b0;
        Reset = 1'b0;
        // reset held with Din high, then release: Rise on 7th edge
        drive(1, 0, 3);
        drive(1, 1, 10);
        // fall after 10 low cycles
        drive(0, 1, 10);
        // 4-cycle pulse rejected, 5-cycle pulse accepted
        drive(1, 1, 4);
        drive(0, 1, 8);
        drive(1, 1, 5);
        drive(0, 1, 12);
        // toggling every 2 cycles, then hold high
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 2);
            drive(0, 1, 2);
        end
        drive(1, 1, 12);
        // reset during a rising qualification (cnt=2)
        drive(0, 1, 12);
        drive(1, 1, 4);
        drive(1, 0, 2);
        drive(0, 1, 8);
        // reset while Q=1
        drive(1, 1, 10);
        drive(1, 0, 2);
        drive(0, 1, 8);
        // randomized segments with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                drive(1'($urandom_range(0, 1)), 0, $urandom_range(1, 2));
            drive(1'($urandom_range(0, 1)), 1, $urandom_range(1, 8));
        end
        drive(0, 1, 12);
        @(negedge Clk);
        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 50000, giving the consecutive synchronized samples beyond the first that are required to accept a level change; legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 16, giving the stability counter width in bits.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-005 SHALL have port Din, input, 1 bit: the raw, asynchronous, bouncing input (pushbutton or switch).
REQ-006 SHALL have port Q, output, 1 bit: the debounced level, used as the D input of the downstream flip-flop stage.
REQ-007 SHALL have port Rise, output, 1 bit: a one-cycle pulse on an accepted 0->1 change of Q.
REQ-008 SHALL have port Fall, output, 1 bit: a one-cycle pulse on an accepted 1->0 change of Q.
REQ-009 SHALL have port Busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-010 SHALL pass Din through a two-flop synchronizer (s1, then s2); only s2 is used by the rest of the logic.
REQ-011 SHALL implement an FSM with four states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
REQ-012 In STABLE_LO with s2=1: go to CHK_HI and set cnt=1; otherwise hold the state.
REQ-013 In CHK_HI with s2=0: return to STABLE_LO and set cnt=0 (glitch rejected); no output pulse.
REQ-014 In CHK_HI with s2=1 and cnt==STABLE_CYCLES: go to STABLE_HI, set Q=1, assert Rise for exactly one cycle, and set cnt=0.
REQ-015 In CHK_HI with s2=1 and cnt<STABLE_CYCLES: increment cnt.
REQ-016 STABLE_HI and CHK_LO SHALL mirror REQ-012..015 with the polarity inverted, clearing Q and pulsing Fall.
REQ-017 Latency: Q and Rise (or Fall) SHALL update on the (STABLE_CYCLES+3)th rising edge of Clk, counting as edge 1 the first edge that samples Din at the new level, provided Din holds that level throughout.
REQ-018 Minimum accepted pulse width SHALL be STABLE_CYCLES+1 cycles; a Din pulse of STABLE_CYCLES cycles or fewer SHALL produce no change on Q and no pulse.
REQ-019 Busy SHALL be 1 exactly when the state is CHK_HI or CHK_LO.
REQ-020 Rise and Fall SHALL never be high in the same cycle, and SHALL never be high in consecutive cycles.
REQ-021 Q SHALL change only on a cycle in which Rise or Fall is asserted.
REQ-022 cnt SHALL never exceed STABLE_CYCLES and SHALL never wrap around.
REQ-023 Q, Rise, Fall and Busy SHALL be registered outputs with no combinational path from Din.

Reset
REQ-024 With Reset=0 at a rising edge of Clk: s1=s2=0, state=STABLE_LO, cnt=0, Q=0, Rise=0, Fall=0, Busy=0.
REQ-025 Reset SHALL override all other activity, including an in-progress qualification.
REQ-026 Reset during CHK_HI SHALL abort the qualification with no Rise pulse.
REQ-027 Reset while Q=1 SHALL clear Q with no Fall pulse.
REQ-028 After Reset returns to 1, the first rising edge of Clk SHALL count as edge 1 of REQ-017 if Din=1 at that edge.

Verification (STABLE_CYCLES=4 unless stated)
REQ-029 Hold Reset=0 for 3 cycles with Din=1 -> Q=0, Rise=0, Fall=0, Busy=0 throughout; release Reset -> Q=1 and a single-cycle Rise on the 7th edge after release.
REQ-030 Din=1 for 4 cycles, then 0 -> Busy pulses high; Q stays 0; no Rise. Din=1 for 5 cycles -> Q=1 and one Rise pulse.
REQ-031 Din toggles every 2 cycles for 20 cycles, then holds at 1 -> exactly one Rise, on the 7th edge after the final 0->1 sample.
REQ-032 With Q=1, Din=0 for 10 cycles -> Fall pulses for one cycle on the 7th edge and Q=0; Rise stays 0 throughout.
REQ-033 Reset=0 asserted in CHK_HI with cnt=2 -> no Rise and Busy=0 on the next cycle; Reset=0 asserted with Q=1 -> Q=0 with Fall=0.
REQ-034 Parameter STABLE_CYCLES=1, Din 0->1 -> Q=1 and Rise on the 4th edge; a 1-cycle Din pulse -> no change on Q.
